// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Opcode/funct encodings, FSM states and ALU operations shared
//               by the multi-cycle MIPS32 core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_BREAK = 6'h0D;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LUI  = 4'd11
   } alu_op_t;

endpackage

`default_nettype wire

// File: rtl/ram.sv
// ============================================================================
// Module      : ram
// Description : Unified word-addressed memory, combinational read and
//               synchronous write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram #(
   parameter int MEM_DEPTH = 2048,
   parameter int AW        = $clog2(MEM_DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [0:MEM_DEPTH-1];

   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdata;
   end

endmodule

`default_nettype wire

// File: rtl/multi_cycle_cpu.sv
// ============================================================================
// Module      : multi_cycle_cpu
// Description : Multi-cycle MIPS32 integer core on one shared datapath.
//               Define MCPU_BREAK_HALT_EN to make break stop the core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_cycle_cpu
   import mips_pkg::*;
#(
   parameter int MEM_DEPTH = 2048
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] regs_debug [0:31],
   output logic [31:0] pc_debug,
   output logic [31:0] instr_debug
);

   localparam int AW = $clog2(MEM_DEPTH);

   state_t      state, next_state;
   alu_op_t     alu_op;
   logic [31:0] pc, ir, a, b, alu_out, mdr;
   logic [31:0] regs [0:31];
   logic [31:0] mem_rdata, imm_ext, alu_b, alu_result, rf_data;
   logic [4:0]  sh_amt, rf_addr;
   logic        is_alu, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr;
   logic        is_brk, valid, rf_we, mem_we;

   wire [5:0]  opcode = ir[31:26];
   wire [4:0]  rs     = ir[25:21];
   wire [4:0]  rt     = ir[20:16];
   wire [4:0]  rd     = ir[15:11];
   wire [4:0]  shamt  = ir[10:6];
   wire [5:0]  funct  = ir[5:0];
   wire [15:0] imm    = ir[15:0];
   wire [31:0] imm_sext = {{16{imm[15]}}, imm};

   assign is_lw  = (opcode == OP_LW);
   assign is_sw  = (opcode == OP_SW);
   assign is_beq = (opcode == OP_BEQ);
   assign is_bne = (opcode == OP_BNE);
   assign is_j   = (opcode == OP_J);
   assign is_jal = (opcode == OP_JAL);
   assign is_jr  = (opcode == OP_RTYPE) && (funct == FN_JR);
   assign is_brk = (opcode == OP_RTYPE) && (funct == FN_BREAK);
   assign valid  = is_alu | is_lw | is_sw | is_beq | is_bne | is_j | is_jal | is_jr;

   // Only R-type ALU ops and ALU-immediates set is_alu; anything else is a NOP.
   always_comb begin
      alu_op = ALU_ADD;
      is_alu = 1'b1;
      if (opcode == OP_RTYPE) begin
         case (funct)
            FN_ADD, FN_ADDU:  alu_op = ALU_ADD;
            FN_SUB, FN_SUBU:  alu_op = ALU_SUB;
            FN_AND:           alu_op = ALU_AND;
            FN_OR:            alu_op = ALU_OR;
            FN_XOR:           alu_op = ALU_XOR;
            FN_NOR:           alu_op = ALU_NOR;
            FN_SLT:           alu_op = ALU_SLT;
            FN_SLTU:          alu_op = ALU_SLTU;
            FN_SLL, FN_SLLV:  alu_op = ALU_SLL;
            FN_SRL, FN_SRLV:  alu_op = ALU_SRL;
            FN_SRA:           alu_op = ALU_SRA;
            default:          is_alu = 1'b0;
         endcase
      end else begin
         case (opcode)
            OP_ADDI, OP_ADDIU: alu_op = ALU_ADD;
            OP_SLTI:           alu_op = ALU_SLT;
            OP_SLTIU:          alu_op = ALU_SLTU;
            OP_ANDI:           alu_op = ALU_AND;
            OP_ORI:            alu_op = ALU_OR;
            OP_XORI:           alu_op = ALU_XOR;
            OP_LUI:            alu_op = ALU_LUI;
            default:           is_alu = 1'b0;
         endcase
      end
   end

   assign imm_ext = (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
                    ? {16'h0000, imm} : imm_sext;
   assign alu_b   = (opcode == OP_RTYPE) ? b : imm_ext;
   assign sh_amt  = (funct == FN_SLLV || funct == FN_SRLV) ? a[4:0] : shamt;

   always_comb begin
      alu_result = '0;
      case (alu_op)
         ALU_ADD:  alu_result = a + alu_b;
         ALU_SUB:  alu_result = a - alu_b;
         ALU_AND:  alu_result = a & alu_b;
         ALU_OR:   alu_result = a | alu_b;
         ALU_XOR:  alu_result = a ^ alu_b;
         ALU_NOR:  alu_result = ~(a | alu_b);
         ALU_SLT:  alu_result = {31'd0, $signed(a) < $signed(alu_b)};
         ALU_SLTU: alu_result = {31'd0, a < alu_b};
         ALU_SLL:  alu_result = alu_b << sh_amt;
         ALU_SRL:  alu_result = alu_b >> sh_amt;
         ALU_SRA:  alu_result = $signed(alu_b) >>> sh_amt;
         ALU_LUI:  alu_result = {imm, 16'h0000};
         default:  alu_result = '0;
      endcase
   end

   // Gating with reset keeps an aborted store from landing on the reset edge.
   assign mem_we = reset && (state == MEM) && is_sw;

   ram #(.MEM_DEPTH(MEM_DEPTH)) i_ram (
      .clk   (clk),
      .we    (mem_we),
      .addr  ((state == MEM) ? alu_out[AW+1:2] : pc[AW+1:2]),
      .wdata (b),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (!reset)
         state <= FETCH;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         FETCH:  next_state = DECODE;
         DECODE: begin
`ifdef MCPU_BREAK_HALT_EN
            if (is_brk)
               next_state = HALT;
            else
`endif
            next_state = valid ? EXEC : FETCH;
         end
         EXEC: begin
            if (is_lw || is_sw)
               next_state = MEM;
            else if (is_alu)
               next_state = WB;
            else
               next_state = FETCH;
         end
         MEM:     next_state = is_lw ? WB : FETCH;
         WB:      next_state = FETCH;
         HALT:    next_state = HALT;
         default: next_state = FETCH;
      endcase
   end

   always_comb begin
      rf_we   = 1'b0;
      rf_addr = rt;
      rf_data = alu_out;
      if (state == WB) begin
         rf_we   = 1'b1;
         rf_addr = (opcode == OP_RTYPE) ? rd : rt;
         rf_data = is_lw ? mdr : alu_out;
      end else if (state == EXEC && is_jal) begin
         rf_we   = 1'b1;
         rf_addr = 5'd31;
         rf_data = pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++)
            regs[i] <= '0;
      end else if (rf_we && rf_addr != 5'd0) begin
         regs[rf_addr] <= rf_data;
      end
   end

   // PC already points past the instruction once FETCH completes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc      <= '0;
         ir      <= '0;
         a       <= '0;
         b       <= '0;
         alu_out <= '0;
         mdr     <= '0;
      end else begin
         case (state)
            FETCH: begin
               ir <= mem_rdata;
               pc <= pc + 32'd4;
            end
            DECODE: begin
               a       <= regs[rs];
               b       <= regs[rt];
               alu_out <= pc + (imm_sext << 2);
            end
            EXEC: begin
               if (is_beq || is_bne) begin
                  if ((a == b) == is_beq)
                     pc <= alu_out;
               end else if (is_j || is_jal) begin
                  pc <= {pc[31:28], ir[25:0], 2'b00};
               end else if (is_jr) begin
                  pc <= a;
               end else begin
                  alu_out <= alu_result;
               end
            end
            MEM: begin
               if (is_lw)
                  mdr <= mem_rdata;
            end
            default: ;
         endcase
      end
   end

   assign regs_debug  = regs;
   assign pc_debug    = pc;
   assign instr_debug = ir;

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_cpu.sv
// ============================================================================
// Module      : tb_multi_cycle_cpu
// Description : Directed and random programs checked against an
//               instruction-level model of the core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_cycle_cpu;

   localparam int DEPTH = 2048;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] regs_debug [0:31];
   logic [31:0] pc_debug;
   logic [31:0] instr_debug;

   multi_cycle_cpu #(.MEM_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .regs_debug  (regs_debug),
      .pc_debug    (pc_debug),
      .instr_debug (instr_debug)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] prog [$];
   logic [31:0] m_mem [0:DEPTH-1];
   logic [31:0] m_reg [0:31];
   logic [31:0] m_pc;
   logic [5:0]  rfn [0:14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                               6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
      return {op, t};
   endfunction

   // Reference model: one architectural instruction per call, with its clock cost.
   task automatic wr(input logic [4:0] r, input logic [31:0] v);
      if (r != 5'd0) m_reg[r] = v;
   endtask

   task automatic iss_step(output int cyc);
      logic [31:0] ins, a, b, se, ze, npc, nxt, addr;
      logic [4:0]  sh;
      ins  = m_mem[m_pc[12:2]];
      a    = m_reg[ins[25:21]];
      b    = m_reg[ins[20:16]];
      sh   = ins[10:6];
      se   = {{16{ins[15]}}, ins[15:0]};
      ze   = {16'h0000, ins[15:0]};
      npc  = m_pc + 32'd4;
      nxt  = npc;
      addr = a + se;
      cyc  = 2;
      case (ins[31:26])
         6'h00: begin
            cyc = 4;
            case (ins[5:0])
               6'h20, 6'h21: wr(ins[15:11], a + b);
               6'h22, 6'h23: wr(ins[15:11], a - b);
               6'h24: wr(ins[15:11], a & b);
               6'h25: wr(ins[15:11], a | b);
               6'h26: wr(ins[15:11], a ^ b);
               6'h27: wr(ins[15:11], ~(a | b));
               6'h2A: wr(ins[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
               6'h2B: wr(ins[15:11], (a < b) ? 32'd1 : 32'd0);
               6'h00: wr(ins[15:11], b << sh);
               6'h02: wr(ins[15:11], b >> sh);
               6'h03: wr(ins[15:11], $signed(b) >>> sh);
               6'h04: wr(ins[15:11], b << a[4:0]);
               6'h06: wr(ins[15:11], b >> a[4:0]);
               6'h08: begin nxt = a; cyc = 3; end
               default: cyc = 2;
            endcase
         end
         6'h08, 6'h09: begin wr(ins[20:16], a + se); cyc = 4; end
         6'h0A: begin wr(ins[20:16], ($signed(a) < $signed(se)) ? 32'd1 : 32'd0); cyc = 4; end
         6'h0B: begin wr(ins[20:16], (a < se) ? 32'd1 : 32'd0); cyc = 4; end
         6'h0C: begin wr(ins[20:16], a & ze); cyc = 4; end
         6'h0D: begin wr(ins[20:16], a | ze); cyc = 4; end
         6'h0E: begin wr(ins[20:16], a ^ ze); cyc = 4; end
         6'h0F: begin wr(ins[20:16], {ins[15:0], 16'h0000}); cyc = 4; end
         6'h23: begin wr(ins[20:16], m_mem[addr[12:2]]); cyc = 5; end
         6'h2B: begin m_mem[addr[12:2]] = b; cyc = 4; end
         6'h04: begin if (a == b) nxt = npc + (se << 2); cyc = 3; end
         6'h05: begin if (a != b) nxt = npc + (se << 2); cyc = 3; end
         6'h02: begin nxt = {npc[31:28], ins[25:0], 2'b00}; cyc = 3; end
         6'h03: begin wr(5'd31, npc); nxt = {npc[31:28], ins[25:0], 2'b00}; cyc = 3; end
         default: cyc = 2;
      endcase
      m_pc = nxt;
   endtask

   task automatic iss_run(input logic [31:0] halt_pc, output int cycles);
      int c;
      int n;
      n = 0;
      cycles = 0;
      m_pc = '0;
      for (int r = 0; r < 32; r++) m_reg[r] = '0;
      while (m_pc != halt_pc && n < 2000) begin
         iss_step(c);
         cycles += c;
         n++;
      end
   endtask

   // Loads prog into DUT and model, holds reset for two clocks, checks reset state.
   task automatic start_program(input string name);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         dut.i_ram.mem[i] = '0;
         m_mem[i] = '0;
      end
      for (int i = 0; i < prog.size(); i++) begin
         dut.i_ram.mem[i] = prog[i];
         m_mem[i] = prog[i];
      end
      repeat (2) @(negedge clk);
      check({name, " reset pc"}, pc_debug, 32'h0);
      check({name, " reset ir"}, instr_debug, 32'h0);
      for (int r = 0; r < 32; r++)
         check($sformatf("%s reset r%0d", name, r), regs_debug[r], 32'h0);
      reset = 1'b1;
   endtask

   task automatic run_and_compare(input string name, input logic [31:0] halt_pc, input int pre);
      int cyc;
      iss_run(halt_pc, cyc);
      repeat (cyc - pre) @(negedge clk);
      check({name, " pc"}, pc_debug, m_pc);
      for (int r = 0; r < 32; r++)
         check($sformatf("%s r%0d", name, r), regs_debug[r], m_reg[r]);
   endtask

   task automatic gen_random();
      logic [4:0] rs, rt, rd;
      prog.delete();
      for (int r = 1; r < 8; r++) begin
         prog.push_back(enc_i(6'h0F, 5'd0, 5'(r), 16'($urandom)));
         prog.push_back(enc_i(6'h0D, 5'(r), 5'(r), 16'($urandom)));
      end
      for (int k = 0; k < 14; k++) begin
         rs = 5'($urandom_range(0, 7));
         rt = 5'($urandom_range(0, 7));
         rd = 5'($urandom_range(0, 7));
         case ($urandom_range(0, 10))
            0, 1, 2, 3: prog.push_back(enc_r(rfn[$urandom_range(0, 14)], rs, rt, rd,
                                             5'($urandom)));
            4, 5: prog.push_back(enc_i(6'(8 + $urandom_range(0, 7)), rs, rt, 16'($urandom)));
            6: prog.push_back(enc_i(6'h2B, 5'd0, rt, 16'(32'h400 + 4 * $urandom_range(0, 15))));
            7: prog.push_back(enc_i(6'h23, 5'd0, rt, 16'(32'h400 + 4 * $urandom_range(0, 15))));
            8: prog.push_back(enc_i(6'h04, rs, rt, 16'h0001));
            9: prog.push_back(enc_i(6'h05, rs, rt, 16'h0001));
            default: prog.push_back(($urandom_range(0, 1) == 0) ? enc_r(6'h3F, rs, rt, rd, 5'd0)
                                                                 : enc_i(6'h3E, rs, rt, 16'h0));
         endcase
      end
      prog.push_back(enc_i(6'h08, 5'd1, 5'd1, 16'h0001));
      prog.push_back(enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] halt;
      logic        found;

      // ALU sequence with exact per-instruction timing
      prog = '{enc_i(6'h08, 5'd0, 5'd8, 16'd5),
               enc_i(6'h08, 5'd0, 5'd9, 16'hFFFD),
               enc_r(6'h20, 5'd8, 5'd9, 5'd10, 5'd0),
               enc_i(6'h0F, 5'd0, 5'd11, 16'h1234),
               enc_i(6'h0D, 5'd11, 5'd11, 16'h5678),
               enc_i(6'h08, 5'd0, 5'd0, 16'd7),
               enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF)};
      start_program("alu");
      @(negedge clk);
      check("alu first fetch pc", pc_debug, 32'h4);
      repeat (3) @(negedge clk);
      check("alu pc after 4 clk", pc_debug, 32'h4);
      check("alu ir", instr_debug, prog[0]);
      @(negedge clk);
      check("alu second fetch pc", pc_debug, 32'h8);
      run_and_compare("alu", 32'h18, 5);
      check("alu t2", regs_debug[10], 32'h2);
      check("alu t3", regs_debug[11], 32'h12345678);
      check("alu zero reg", regs_debug[0], 32'h0);

      // Reset during a store's MEM cycle must suppress the write
      prog = '{enc_i(6'h08, 5'd0, 5'd8, 16'h00AB),
               enc_i(6'h2B, 5'd0, 5'd8, 16'h0100),
               enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF)};
      start_program("abort");
      repeat (7) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("abort mem64", dut.i_ram.mem[64], 32'h0);
      check("abort pc", pc_debug, 32'h0);
      check("abort t0", regs_debug[8], 32'h0);
      reset = 1'b1;
      run_and_compare("abort rerun", 32'h8, 0);
      check("abort rerun mem64", dut.i_ram.mem[64], 32'hAB);

      // Store then load
      prog = '{enc_i(6'h08, 5'd0, 5'd8, 16'h00AB),
               enc_i(6'h2B, 5'd0, 5'd8, 16'h0100),
               enc_i(6'h23, 5'd0, 5'd2, 16'h0100),
               enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF)};
      start_program("mem");
      run_and_compare("mem", 32'hC, 0);
      check("mem v0", regs_debug[2], 32'hAB);
      check("mem word64", dut.i_ram.mem[64], 32'hAB);

      // Branches, jal and jr
      prog = '{enc_i(6'h08, 5'd0, 5'd8, 16'd1),
               enc_i(6'h08, 5'd0, 5'd9, 16'd1),
               enc_i(6'h04, 5'd8, 5'd9, 16'h0001),
               enc_i(6'h08, 5'd0, 5'd16, 16'h0055),
               enc_i(6'h05, 5'd8, 5'd9, 16'h0001),
               enc_i(6'h08, 5'd0, 5'd17, 16'h0066),
               enc_i(6'h08, 5'd0, 5'd18, 16'h0011),
               32'h0,
               enc_j(6'h03, 26'd12),
               enc_i(6'h08, 5'd0, 5'd19, 16'h0077),
               enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF),
               32'h0,
               enc_i(6'h08, 5'd0, 5'd20, 16'h0044),
               enc_r(6'h08, 5'd31, 5'd0, 5'd0, 5'd0)};
      start_program("ctl");
      run_and_compare("ctl", 32'h28, 0);
      check("ctl beq skipped", regs_debug[16], 32'h0);
      check("ctl bne fallthrough", regs_debug[17], 32'h66);
      check("ctl jal ra", regs_debug[31], 32'h24);
      check("ctl jal target", regs_debug[20], 32'h44);
      check("ctl jr return", regs_debug[19], 32'h77);

      // Checksum kernel: sum of four words at 0x200
      prog = '{enc_i(6'h08, 5'd0, 5'd8, 16'h0200),
               enc_i(6'h08, 5'd0, 5'd9, 16'd4),
               enc_i(6'h08, 5'd0, 5'd2, 16'd0),
               enc_i(6'h23, 5'd8, 5'd10, 16'd0),
               enc_r(6'h21, 5'd2, 5'd10, 5'd2, 5'd0),
               enc_i(6'h08, 5'd8, 5'd8, 16'd4),
               enc_i(6'h08, 5'd9, 5'd9, 16'hFFFF),
               enc_i(6'h05, 5'd9, 5'd0, 16'hFFFB),
               enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF)};
      while (prog.size() < 128) prog.push_back(32'h0);
      prog.push_back(32'h10);
      prog.push_back(32'h20);
      prog.push_back(32'h30);
      prog.push_back(32'h4A);
      start_program("cksum");
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         @(negedge clk);
         if (regs_debug[2] === 32'hAA) found = 1'b1;
      end
      check("cksum v0 within 300", regs_debug[2], 32'hAA);

      // Random programs against the model
      for (int t = 0; t < 8; t++) begin
         gen_random();
         halt = 32'(4 * (prog.size() - 1));
         start_program($sformatf("rnd%0d", t));
         run_and_compare($sformatf("rnd%0d", t), halt, 0);
         for (int i = 256; i < 272; i++)
            check($sformatf("rnd%0d mem%0d", t, i), dut.i_ram.mem[i], m_mem[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/multi_cycle_cpu.md
Name: multi_cycle_cpu

Overview:
Multi-cycle, non-pipelined MIPS32 integer core with one unified instruction/data memory. Each instruction passes through a shared-datapath FSM that takes 3–5 clocks. It runs bare-metal test programs such as the checksum kernel. It exposes the register file, PC and current instruction as debug outputs for benches.

Parameters:
MEM_DEPTH, 2048, number of 32-bit words in the unified memory.

Ports:
clk  input  1  single system clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset (asserted when 0).
regs_debug  output  32x32 (unpacked [0:31] of [31:0])  live register file contents; index 2 is $v0.
pc_debug  output  32  current PC (byte address).
instr_debug  output  32  contents of the instruction register.

Behaviour:
- Interface rule: one clock; reset is synchronous and active-low.
- Reset (reset==0 at a clk edge):
  - PC, IR, A, B, ALUOut and MDR clear to 0.
  - All 32 registers clear to 0.
  - FSM goes to FETCH.
  - Memory contents are preserved.
  - Reset asserted mid-instruction aborts it; no register or memory write occurs on that edge.
- Memory:
  - Submodule instance i_ram with array mem[0:MEM_DEPTH-1]; benches preload it by hierarchical path.
  - Word index = addr[$clog2(MEM_DEPTH)+1:2], wrapping modulo MEM_DEPTH.
  - Combinational read; synchronous write. Program starts at address 0.
- FSM states and per-class cycle counts:
  - FETCH: IR<=mem[PC], PC<=PC+4.
  - DECODE: A<=rs, B<=rt, ALUOut<=PC+(sext(imm)<<2).
  - EXEC: ALU result to ALUOut; branch or jump resolves here.
  - MEM: load reads into MDR; store writes B.
  - WB: register write.
  - R-type and ALU-immediate: 4 cycles. lw: 5. sw: 4. beq/bne/j/jal/jr: 3.
- Instruction set, no delay slots:
  - R-type: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, jr.
  - I-type: addi, addiu, slti, sltiu, andi, ori, xori, lui, lw, sw, beq, bne.
  - J-type: j, jal.
- Arithmetic and field rules:
  - All arithmetic wraps modulo 2^32; no overflow traps.
  - andi/ori/xori zero-extend the immediate; other immediates sign-extend.
  - lui: rt = imm<<16.
  - slt is signed; sltu is unsigned.
  - sll/srl/sra use shamt; sllv/srlv use rs[4:0].
- Control flow:
  - Branch target = PC+4 + (sext(imm)<<2).
  - j/jal target = {PC+4[31:28], target26, 2'b00}.
  - jal writes $31 = PC+4 (address of the next instruction).
- Register file: writes to $0 are ignored; register 0 always reads 0.
- Undefined opcode or funct: executes as NOP and returns to FETCH after DECODE.

Optional Feature:
MCPU_BREAK_HALT_EN:
- Defined: funct 0x0D (break) enters HALT. HALT holds PC, registers and memory until reset.
- Undefined: break executes as NOP.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct localparams;
  - state_t enum (FETCH, DECODE, EXEC, MEM, WB, HALT);
  - alu_op_t enum.
- Sub-module: ram. It is parameterised by MEM_DEPTH and instantiated as i_ram with array name mem; the instance and array names are mandatory.
- Register file and ALU stay inline.

Test Plan:
- Reset: reset=0 for 2 clocks -> pc_debug=0, all regs_debug=0. After release, FETCH of word 0 -> pc_debug=4 one clock later.
- ALU: addi $t0,$0,5; addi $t1,$0,-3; add $t2,$t0,$t1; lui $t3,0x1234; ori $t3,$t3,0x5678 -> $t2=2, $t3=0x12345678. Each instruction takes 4 clocks.
- Memory: addi $t0,$0,0xAB; sw $t0,0x100($0); lw $v0,0x100($0) -> $v0=0xAB; i_ram.mem[64]=0xAB.
- Control flow:
  - beq taken skips the next instruction; bne not taken falls through.
  - jal at 0x20 -> $ra=0x24.
  - jr $ra returns to 0x24.
- Checksum program preloaded -> regs_debug[2]==0x000000AA within 300 clocks after reset release.
- $0 write: addi $0,$0,7 -> regs_debug[0] stays 0.
